n_piso_serializer: RTL
======================

Name: n_piso_serializer

Overview:
- Parallel-in, serial-out shift stage that sits directly downstream of the n_pipo register.
- Accepts the registered N-bit word Q through a valid/ready handshake and emits it one bit per enabled clock on a serial line, with framing strobes.
- Supports back-to-back words with no idle gap, pacing through a shift enable, and an optional parity bit.

Parameters:
- N, 4, data word width; legal range is 2 or more.
- MSB_FIRST, 1, 1 means d[N-1] is shifted out first; 0 means d[0] is shifted out first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  asynchronous, active-low reset.
- d  input  N  parallel word, driven by the n_pipo Q output.
- load_valid  input  1  upstream asserts that d holds a word to send.
- load_ready  output  1  serializer can accept d this cycle.
- shift_en  input  1  bit-rate enable; when low, all shifting stalls.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out holds a valid bit this cycle.
- frame_start  output  1  high while the first bit of a word is on ser_out.
- frame_end  output  1  high while the last bit of a word (or the parity bit) is on ser_out.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (clear=0, asynchronous): state=IDLE, shift register=0, bit counter=0, ser_out=0, ser_valid=0, frame_start=0, frame_end=0, busy=0. Outputs are registered.
- States: IDLE and SHIFT (plus PARITY when the optional feature is enabled).
- Accept condition: load_valid & load_ready.
- load_ready = (state==IDLE) | (last bit on ser_out & shift_en). It is combinational from state and shift_en only, never from load_valid.
- IDLE with accept:
  - Load d into the shift register. The next cycle presents the first bit with ser_valid=1 and frame_start=1.
  - Go to SHIFT with the counter at N-1 bits remaining.
  - Acceptance does not require shift_en.
- SHIFT with shift_en=1: advance one bit (MSB_FIRST selects the shift direction) and decrement the counter.
- SHIFT with shift_en=0: all registers hold, including ser_out, ser_valid and the frame flags.
- Last data bit on ser_out and shift_en=1:
  - If accept also happens in that cycle, reload d, stay in SHIFT, and raise frame_start on the next cycle. This is zero-gap streaming.
  - Otherwise go to IDLE. ser_valid drops the next cycle; ser_out holds its last value.
- Latency: the first bit appears 1 cycle after accept. A word occupies N enabled cycles on the line.
- d is sampled only at accept; later changes to d do not affect the word in flight.
- Reset mid-word: the word is discarded with no partial completion, and the block is in IDLE on the first edge after clear rises.
- load_valid while busy and not on the last bit: no accept, load_ready=0; upstream must hold the word.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, a PARITY state emits the even-parity bit (XOR of the word, latched at accept) as one extra enabled cycle.
  - frame_end moves to the parity bit.
  - load_ready on the last bit is evaluated in PARITY.
  - A word occupies N+1 enabled cycles.
- Undefined: no PARITY state; frame_end is on the last data bit.

Decomposition:
- Package piso_pkg holds:
  - the state enum: IDLE, SHIFT, PARITY;
  - the localparam CNT_W = $clog2(N+1), as a function of N;
  - the MSB_FIRST encoding constants.
- One natural sub-module, piso_bit_counter: loadable down-counter with enable, width CNT_W, with a last output (count==0).

Test Plan:
- Reset, then load_valid=1 with d=4'b1010, shift_en=1 and MSB_FIRST=1:
  - ser_out must be 1,0,1,0 on the 4 cycles after accept.
  - frame_start must be on the first bit and frame_end on the fourth.
  - ser_valid must drop on cycle 5.
- Back-to-back: d=4'b1100 and then 4'b1001 with load_valid held:
  - ser_out must be 1,1,0,0,1,0,0,1 with no gap.
  - load_ready must pulse exactly on each last bit.
- Stall: send 4'b1111 with shift_en=0 for 3 cycles after the second bit; ser_out and ser_valid must hold, and the total word takes 7 cycles.
- Assert clear=0 mid-word after 2 bits, release after 1 cycle:
  - all outputs must be 0 and state IDLE;
  - the next accepted d=4'b0110 must serialize cleanly.
- MSB_FIRST=0 with d=4'b0001: ser_out must be 1,0,0,0.
- With PISO_PARITY_EN defined, d=4'b1011: ser_out must be 1,0,1,1,1, with frame_end on the fifth bit.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the n_piso_serializer block: state encoding,
// counter width helper and bit-order encoding.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam bit LSB_FIRST_ORDER = 1'b0;
  localparam bit MSB_FIRST_ORDER = 1'b1;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with enable; saturates at zero and flags last (count==0).
module piso_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == '0);

endmodule

// File: rtl/n_piso_serializer.sv
// Parallel-in serial-out stage with valid/ready load and zero-gap streaming.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
module n_piso_serializer
  import piso_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [N-1:0] d,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         shift_en,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         frame_start,
  output logic         frame_end,
  output logic         busy
);

  localparam int CNT_W = cnt_width(N);
`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic             parity_q, parity_d;
  logic             cnt_load, cnt_en, cnt_last;
  logic [CNT_W-1:0] cnt_count;
  logic             on_last, accept;

  piso_bit_counter #(.W(CNT_W)) u_bit_counter (
    .clk        (clk),
    .clear      (clear),
    .load       (cnt_load),
    .load_value (CNT_W'(N - 1)),
    .en         (cnt_en),
    .count      (cnt_count),
    .last       (cnt_last)
  );

  // The final bit of a frame is the parity bit when enabled, else the last data bit.
  assign on_last    = PARITY_EN ? (state_q == PARITY) : ((state_q == SHIFT) && cnt_last);
  assign load_ready = (state_q == IDLE) || (on_last && shift_en);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    ser_out_d     = ser_out_q;
    ser_valid_d   = ser_valid_q;
    frame_start_d = frame_start_q;
    frame_end_d   = frame_end_q;
    parity_d      = parity_q;
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;
    if (accept) begin
      state_d       = SHIFT;
      cnt_load      = 1'b1;
      parity_d      = ^d;
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      frame_end_d   = 1'b0;
      if (MSB_FIRST == MSB_FIRST_ORDER) begin
        ser_out_d = d[N-1];
        shreg_d   = {d[N-2:0], 1'b0};
      end else begin
        ser_out_d = d[0];
        shreg_d   = {1'b0, d[N-1:1]};
      end
    end else if (shift_en) begin
      case (state_q)
        SHIFT: begin
          if (!cnt_last) begin
            cnt_en        = 1'b1;
            frame_start_d = 1'b0;
            frame_end_d   = !PARITY_EN && (cnt_count == CNT_W'(1));
            if (MSB_FIRST == MSB_FIRST_ORDER) begin
              ser_out_d = shreg_q[N-1];
              shreg_d   = {shreg_q[N-2:0], 1'b0};
            end else begin
              ser_out_d = shreg_q[0];
              shreg_d   = {1'b0, shreg_q[N-1:1]};
            end
          end else if (PARITY_EN) begin
            state_d       = PARITY;
            ser_out_d     = parity_q;
            frame_start_d = 1'b0;
            frame_end_d   = 1'b1;
          end else begin
            state_d       = IDLE;
            ser_valid_d   = 1'b0;
            frame_start_d = 1'b0;
            frame_end_d   = 1'b0;
          end
        end
        PARITY: begin
          state_d       = IDLE;
          ser_valid_d   = 1'b0;
          frame_start_d = 1'b0;
          frame_end_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      parity_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      parity_q      <= parity_d;
    end
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign busy        = (state_q != IDLE);

endmodule
